// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment codes, digit limits and BCD decoder for the scan counter
package seven_seg_pkg;
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W = $clog2(MAX_DIGITS);
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/pulse_div.sv
// pulse_div: free-running modulo-DIV counter, pulse high while the count sits at DIV-1
module pulse_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic pulse
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign pulse = en && cnt == W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= pulse ? '0 : cnt + W'(1);
endmodule

// File: rtl/seven_seg_scan_counter.sv
// seven_seg_scan_counter: N-digit up/down BCD counter multiplexed onto a shared
// active-low seven-segment bus with one dead cycle between digits.
module seven_seg_scan_counter
    import seven_seg_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    up_dn,
    input  logic                    blank_lz,
    output logic [6:0]              cathode,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    wrap
);
    logic                    tick;
    logic                    scanPulse;
    logic [NUM_DIGITS:0]     carry;
    logic [NUM_DIGITS:0]     lz;
    logic [4*NUM_DIGITS-1:0] bcdNext;
    logic [IDX_W-1:0]        scanIdx;
    logic [3:0]              digSel;
    logic                    blankSel;

    pulse_div #(.DIV(TICK_DIV)) tickDiv (.clk, .rst_n, .en, .clr, .pulse(tick));
    pulse_div #(.DIV(SCAN_DIV)) scanDiv (.clk, .rst_n, .en(1'b1), .clr(1'b0), .pulse(scanPulse));

    assign carry[0] = 1'b1;
    assign lz[NUM_DIGITS] = blank_lz;

    // carry doubles as borrow; lz[k] marks digit k as a blankable leading zero
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : gDigit
        logic [3:0] d;
        assign d = bcd[4*k +: 4];
        assign carry[k+1] = carry[k] && d == (up_dn ? 4'd9 : 4'd0);
        assign bcdNext[4*k +: 4] = !carry[k] ? d :
                                   up_dn ? (d == 4'd9 ? 4'd0 : d + 4'd1) :
                                           (d == 4'd0 ? 4'd9 : d - 4'd1);
        if (k == 0) begin : gLsd
            assign lz[k] = 1'b0;
        end else begin : gUpper
            assign lz[k] = lz[k+1] && d == 4'd0;
        end
    end

    always_comb begin
        digSel = bcd[3:0];
        blankSel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (scanIdx == IDX_W'(k)) begin
                digSel = bcd[4*k +: 4];
                blankSel = lz[k];
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bcd <= '0;
            wrap <= 1'b0;
            scanIdx <= '0;
            anode <= '1;
            cathode <= SEG_BLANK;
        end else begin
            bcd <= clr ? '0 : tick ? bcdNext : bcd;
            wrap <= !clr && tick && carry[NUM_DIGITS];
            if (scanPulse)
                scanIdx <= scanIdx == IDX_W'(NUM_DIGITS - 1) ? '0 : scanIdx + IDX_W'(1);
            anode <= scanPulse ? '1 : ~(NUM_DIGITS'(1) << scanIdx);
            cathode <= blankSel ? SEG_BLANK : bcd_to_seg(digSel);
        end
endmodule

// File: tb/tb_seven_seg_scan_counter.sv
// tb_seven_seg_scan_counter: directed checks of counting, wrap, scan, blanking, clear and reset
module tb_seven_seg_scan_counter;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        up_dn;
    logic        blank_lz;
    logic [6:0]  cathode;
    logic [3:0]  anode;
    logic [15:0] bcd;
    logic        wrap;
    int          cyc;
    int          nVec;
    int          nErr;

    seven_seg_scan_counter #(.TICK_DIV(4), .SCAN_DIV(3), .NUM_DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .up_dn(up_dn),
        .blank_lz(blank_lz), .cathode(cathode), .anode(anode), .bcd(bcd), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rising edges since the last reset release; sampled on falling edges
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic do_reset(input logic enV, input logic upV, input logic blankV);
        rst_n = 1'b0;
        en = enV;
        up_dn = upV;
        blank_lz = blankV;
        clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_bcd(input string name, input logic [15:0] exp);
        nVec++;
        if (bcd !== exp) begin
            nErr++;
            $display("FAIL %s @cyc %0d: bcd=%h expected %h", name, cyc, bcd, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0; clr = 1'b0; up_dn = 1'b1; blank_lz = 1'b0;
        @(negedge clk);
        nVec += 4;
        if (bcd !== 16'h0000) begin nErr++; $display("FAIL reset_bcd: bcd=%h expected 0000", bcd); end
        if (anode !== 4'hF) begin nErr++; $display("FAIL reset_anode: anode=%b expected 1111", anode); end
        if (cathode !== 7'b1111111) begin nErr++; $display("FAIL reset_cathode: cathode=%b expected 1111111", cathode); end
        if (wrap !== 1'b0) begin nErr++; $display("FAIL reset_wrap: wrap=%b expected 0", wrap); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_up;
        do_reset(1'b1, 1'b1, 1'b0);
        wait_cyc(3);  chk_bcd("count_before_first_tick", 16'h0000);
        wait_cyc(4);  chk_bcd("count_first_tick", 16'h0001);
        wait_cyc(7);  chk_bcd("count_hold_between_ticks", 16'h0001);
        wait_cyc(36); chk_bcd("count_9_ticks", 16'h0009);
        wait_cyc(40); chk_bcd("count_10_ticks", 16'h0010);
    endtask

    task automatic test_wrap;
        do_reset(1'b1, 1'b0, 1'b0);
        wait_cyc(3);
        nVec++;
        if (wrap !== 1'b0) begin nErr++; $display("FAIL wrap_idle: wrap=%b expected 0", wrap); end
        wait_cyc(4);
        chk_bcd("down_wrap_value", 16'h9999);
        nVec++;
        if (wrap !== 1'b1) begin nErr++; $display("FAIL down_wrap_pulse: wrap=%b expected 1", wrap); end
        wait_cyc(5);
        nVec++;
        if (wrap !== 1'b0) begin nErr++; $display("FAIL down_wrap_width: wrap=%b expected 0", wrap); end
        up_dn = 1'b1;
        wait_cyc(8);
        chk_bcd("up_wrap_value", 16'h0000);
        nVec++;
        if (wrap !== 1'b1) begin nErr++; $display("FAIL up_wrap_pulse: wrap=%b expected 1", wrap); end
        wait_cyc(9);
        nVec++;
        if (wrap !== 1'b0) begin nErr++; $display("FAIL up_wrap_width: wrap=%b expected 0", wrap); end
        up_dn = 1'b0;
        wait_cyc(12);
        chk_bcd("down_wrap_again", 16'h9999);
        wait_cyc(16);
        chk_bcd("down_borrow", 16'h9998);
        nVec++;
        if (wrap !== 1'b0) begin nErr++; $display("FAIL borrow_no_wrap: wrap=%b expected 0", wrap); end
    endtask

    task automatic test_scan;
        logic [3:0] expAn [13] = '{4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1111,
                                   4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b1111, 4'b1110};
        logic [6:0] expCa [13] = '{7'b0000001, 7'b0000001, 7'b0, 7'b1111111, 7'b1111111, 7'b0,
                                   7'b1111111, 7'b1111111, 7'b0, 7'b1111111, 7'b1111111, 7'b0, 7'b0000001};
        do_reset(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 13; i++) begin
            wait_cyc(i + 1);
            nVec++;
            if (anode !== expAn[i]) begin
                nErr++;
                $display("FAIL scan_anode_%0d: anode=%b expected %b", i + 1, anode, expAn[i]);
            end
            if (expAn[i] != 4'hF) begin
                nVec++;
                if (cathode !== expCa[i]) begin
                    nErr++;
                    $display("FAIL scan_zero_blank_%0d: cathode=%b expected %b", i + 1, cathode, expCa[i]);
                end
            end
        end
    endtask

    task automatic test_digits_0123;
        int         cy [6] = '{493, 496, 499, 502, 514, 517};
        logic [3:0] an [6] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
        logic [6:0] ca [6] = '{7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001, 7'b1111111, 7'b0000110};
        do_reset(1'b1, 1'b1, 1'b0);
        wait_cyc(400); chk_bcd("carry_to_hundreds", 16'h0100);
        wait_cyc(492); chk_bcd("count_123", 16'h0123);
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                wait_cyc(512);
                chk_bcd("en_low_hold", 16'h0123);
                blank_lz = 1'b1;
            end
            wait_cyc(cy[i]);
            nVec += 2;
            if (anode !== an[i]) begin
                nErr++;
                $display("FAIL digit_anode_%0d: anode=%b expected %b", cy[i], anode, an[i]);
            end
            if (cathode !== ca[i]) begin
                nErr++;
                $display("FAIL digit_cathode_%0d: cathode=%b expected %b", cy[i], cathode, ca[i]);
            end
        end
    endtask

    task automatic test_blank_0040;
        int         cy [4] = '{169, 172, 175, 178};
        logic [3:0] an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] ca [4] = '{7'b0000001, 7'b1001100, 7'b1111111, 7'b1111111};
        do_reset(1'b1, 1'b1, 1'b1);
        wait_cyc(160);
        chk_bcd("count_40", 16'h0040);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(cy[i]);
            nVec += 2;
            if (anode !== an[i]) begin
                nErr++;
                $display("FAIL lz_anode_%0d: anode=%b expected %b", cy[i], anode, an[i]);
            end
            if (cathode !== ca[i]) begin
                nErr++;
                $display("FAIL lz_cathode_%0d: cathode=%b expected %b", cy[i], cathode, ca[i]);
            end
        end
    endtask

    task automatic test_clear;
        do_reset(1'b1, 1'b0, 1'b0);
        wait_cyc(3);
        clr = 1'b1;
        wait_cyc(4);
        clr = 1'b0;
        chk_bcd("clr_beats_tick", 16'h0000);
        nVec++;
        if (wrap !== 1'b0) begin nErr++; $display("FAIL clr_no_wrap: wrap=%b expected 0", wrap); end
        wait_cyc(8);
        chk_bcd("after_clr_tick", 16'h9999);
        up_dn = 1'b1;
        wait_cyc(12);
        chk_bcd("after_clr_up", 16'h0000);
        wait_cyc(13);
        clr = 1'b1;
        wait_cyc(14);
        clr = 1'b0;
        wait_cyc(17);
        chk_bcd("clr_restarts_divider", 16'h0000);
        wait_cyc(18);
        chk_bcd("tick_after_clr", 16'h0001);
    endtask

    task automatic test_enable_hold;
        do_reset(1'b1, 1'b1, 1'b0);
        wait_cyc(5);
        chk_bcd("en_first_tick", 16'h0001);
        en = 1'b0;
        wait_cyc(25);
        chk_bcd("en_low_20_cycles", 16'h0001);
        nVec++;
        if (anode !== 4'b1110) begin nErr++; $display("FAIL en_low_scan_25: anode=%b expected 1110", anode); end
        en = 1'b1;
        wait_cyc(27);
        chk_bcd("en_resume_wait", 16'h0001);
        wait_cyc(28);
        chk_bcd("en_resume_tick", 16'h0002);
        nVec++;
        if (anode !== 4'b1101) begin nErr++; $display("FAIL en_low_scan_28: anode=%b expected 1101", anode); end
    endtask

    task automatic test_async_reset;
        do_reset(1'b1, 1'b1, 1'b0);
        wait_cyc(10);
        chk_bcd("pre_reset_count", 16'h0002);
        #2 rst_n = 1'b0;
        #1;
        nVec += 4;
        if (anode !== 4'hF) begin nErr++; $display("FAIL async_anode: anode=%b expected 1111", anode); end
        if (cathode !== 7'b1111111) begin nErr++; $display("FAIL async_cathode: cathode=%b expected 1111111", cathode); end
        if (bcd !== 16'h0000) begin nErr++; $display("FAIL async_bcd: bcd=%h expected 0000", bcd); end
        if (wrap !== 1'b0) begin nErr++; $display("FAIL async_wrap: wrap=%b expected 0", wrap); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        nVec += 2;
        if (anode !== 4'b1110) begin nErr++; $display("FAIL post_reset_anode: anode=%b expected 1110", anode); end
        if (cathode !== 7'b0000001) begin nErr++; $display("FAIL post_reset_cathode: cathode=%b expected 0000001", cathode); end
        wait_cyc(3);
        chk_bcd("post_reset_no_early_tick", 16'h0000);
        wait_cyc(4);
        chk_bcd("post_reset_first_tick", 16'h0001);
    endtask

    initial begin
        nVec = 0;
        nErr = 0;
        rst_n = 1'b1;
        en = 1'b0; clr = 1'b0; up_dn = 1'b1; blank_lz = 1'b0;
        #2;
        test_reset();
        test_count_up();
        test_wrap();
        test_scan();
        test_digits_0123();
        test_blank_0040();
        test_clear();
        test_enable_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/seven_seg_scan_counter.md
# seven_seg_scan_counter

Parametrised multi-digit decimal counter with a time-multiplexed seven-segment display driver. A free-running divider generates count ticks that advance an N-digit BCD counter, up or down, with wrap and leading-zero blanking. A second divider scans the digits onto one shared active-low cathode bus with one-hot active-low anodes. It sits between the board clock and the display pins, and supersedes the single-digit 0–9 cathode counter.

## Interface
- TICK_DIV, 100_000_000: clk cycles per count tick; must be ≥ 2.
- SCAN_DIV, 100_000: clk cycles each digit stays selected; must be ≥ 2.
- NUM_DIGITS, 4: number of BCD digits and anodes; range 1–8.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  count enable; when low, the tick divider and counter hold.
- clr  in  1  synchronous clear of the counter and tick divider.
- up_dn  in  1  direction: 1 counts up, 0 counts down.
- blank_lz  in  1  enables leading-zero blanking.
- cathode  out  7  segments {a,b,c,d,e,f,g} in bits [6:0]; active-low.
- anode  out  NUM_DIGITS  digit select, one-hot, active-low; bit 0 is the least significant digit.
- bcd  out  4*NUM_DIGITS  counter value; digit k is in bits [4k+3:4k].
- wrap  out  1  one-cycle pulse when the counter rolls over.

## Operation
- Reset (rst_n=0, asynchronous) sets the following values: bcd=0, both dividers=0, scan index=0, anode=all 1s, cathode=7'b1111111, wrap=0.
- Tick divider: when en=1, counts 0..TICK_DIV-1; tick=1 in the cycle the count equals TICK_DIV-1, and the count then returns to 0. Tick period is exactly TICK_DIV cycles, with no off-by-one.
- Counter update, applied on a tick:
  - Up: increment digit 0; a digit at 9 goes to 0 and carries into the next digit.
  - Down: decrement digit 0; a digit at 0 goes to 9 and borrows from the next digit.
  - All-9s up → all-0s with wrap=1. All-0s down → all-9s with wrap=1.
- clr=1: bcd=0, tick divider=0, no wrap. clr has priority over a simultaneous tick. The scan path is unaffected.
- Scan divider: always runs, regardless of en or clr. Each time it completes SCAN_DIV cycles, the scan index advances by 1, going from NUM_DIGITS-1 back to 0.
- Dead time: in the first cycle after a scan index change, anode is forced to all 1s. The new digit's anode asserts one cycle later.
- Segment codes (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111; any non-BCD code displays as blank.
- Leading-zero blanking: when blank_lz=1, every digit above the most significant nonzero digit displays blank. Digit 0 is never blanked.
- up_dn and blank_lz may change at any time. They take effect on the next tick and the next output register update, respectively.

## Timing
- Every output is registered.
- bcd and wrap update on the clock edge at which tick=1.
- cathode and anode are registered from the scan index and bcd: one cycle of latency after either changes.
- Digit k is driven for SCAN_DIV-1 cycles with its anode low, plus one dead cycle.
- Full refresh period is NUM_DIGITS*SCAN_DIV cycles.
- Deassertion of rst_n: the first output register update occurs on the first rising edge after rst_n goes high, and shows digit 0 = 0.
- Reset asserted mid-scan or mid-count returns all outputs to their reset values immediately; no partial state survives.

## Structure
- Package seven_seg_pkg contains:
  - SEG_0..SEG_9 and SEG_BLANK localparams.
  - bcd_to_seg function (4-bit input → 7-bit active-low output).
  - Max NUM_DIGITS constant (8).
- Sub-module pulse_div (parameter DIV; ports clk, rst_n, en, clr, pulse). It is instantiated twice:
  - Tick divider: en=en, clr=clr.
  - Scan divider: en=1, clr=0.
- The top level contains the BCD ripple-carry logic (a generate loop over digits), the scan index, the blanking mask, and the output registers.

## Test plan
- Parameters TICK_DIV=4, SCAN_DIV=3, NUM_DIGITS=4, reset then en=1, up_dn=1: bcd increments every 4 cycles; after 10 ticks bcd=16'h0010.
- Preload to 16'h9999 via ticks, then one more tick → bcd=16'h0000 and wrap high for exactly 1 cycle. up_dn=0 from 0000 → bcd=16'h9999 and a wrap pulse.
- Scan check: anode sequence 1110, 1111, 1101, 1111, 1011, … with each digit held for 2 cycles. Cathode equals the segment code of the selected digit; bcd=0123 shows 0010010 on digit 1.
- blank_lz=1 with bcd=16'h0040: digits 3 and 2 show 1111111, digit 1 shows 1001100, digit 0 shows 0000001. bcd=0000 shows only digit 0 as 0000001.
- clr and tick in the same cycle: bcd=0 and wrap=0. en=0 for 20 cycles: bcd unchanged and scanning continues.
- Assert rst_n low mid-count asynchronously (between edges): anode=1111 and cathode=1111111 immediately. After release, the count resumes from 0 and the first tick arrives exactly TICK_DIV cycles later.
